clk_period_meter: RTL and testbench

Measures the period and high time of a slow, divided clock (for example the /2, /4 and /8 outputs of the clock divider) in cycles of the fast system clock. It sits directly downstream of the clock divider and consumes one divided clock. It reports each completed period with a one-cycle valid strobe. It also flags when consecutive periods match (locked) or when a period exceeds the counter range (overflow).

---
 rtl/clk_period_meter_if.sv | 23 ++
 rtl/clk_period_meter.sv | 159 +++++++++++++++
 tb/tb_clk_period_meter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_period_meter_if.sv
// Signal bundle between a divided-clock source/consumer and clk_period_meter.
// The master drives the measured clock and enable; the slave returns the measurements.
interface clk_period_meter_if #(
  parameter int CNT_W = 16
);
  logic             div_clk_in;
  logic             meas_en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             overflow;

  modport master (
    output div_clk_in, meas_en,
    input  period, high_time, period_valid, locked, overflow
  );

  modport slave (
    input  div_clk_in, meas_en,
    output period, high_time, period_valid, locked, overflow
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of a divided clock in system-clock cycles.
// Define CLK_PERIOD_METER_SYNC_EN to add a synchronizer stage for an unrelated source domain.
module clk_period_meter #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  clk_period_meter_if.slave mif
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             smp_q;
  logic             smpDly_q;
  logic             rise_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] highTime_q, highTime_d;
  logic             periodValid_q, periodValid_d;
  logic             locked_q, locked_d;
  logic             overflow_q, overflow_d;
  logic             havePrev_q, havePrev_d;

`ifdef CLK_PERIOD_METER_SYNC_EN
  logic meta_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      smp_q  <= 1'b0;
    end else begin
      meta_q <= mif.div_clk_in;
      smp_q  <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_q <= 1'b0;
    end else begin
      smp_q <= mif.div_clk_in;
    end
  end
`endif

  // Edge detect is registered, so rise_q lines up with smpDly_q as the "current" level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smpDly_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      smpDly_q <= smp_q;
      rise_q   <= smp_q & ~smpDly_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hcnt_q        <= '0;
      period_q      <= '0;
      highTime_q    <= '0;
      periodValid_q <= 1'b0;
      locked_q      <= 1'b0;
      overflow_q    <= 1'b0;
      havePrev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hcnt_q        <= hcnt_d;
      period_q      <= period_d;
      highTime_q    <= highTime_d;
      periodValid_q <= periodValid_d;
      locked_q      <= locked_d;
      overflow_q    <= overflow_d;
      havePrev_q    <= havePrev_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hcnt_d        = hcnt_q;
    period_d      = period_q;
    highTime_d    = highTime_q;
    periodValid_d = 1'b0;
    locked_d      = locked_q;
    overflow_d    = overflow_q;
    havePrev_d    = havePrev_q;

    // Enable low overrides everything, including a strobe that would otherwise fire this edge.
    if (!mif.meas_en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      hcnt_d     = '0;
      locked_d   = 1'b0;
      overflow_d = 1'b0;
      havePrev_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = ARM;
          cnt_d      = '0;
          hcnt_d     = '0;
          havePrev_d = 1'b0;
        end
        ARM: begin
          havePrev_d = 1'b0;
          if (rise_q) begin
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // A rise takes priority over the overflow check at cnt == max.
          if (rise_q) begin
            period_d      = cnt_q;
            highTime_d    = hcnt_q;
            periodValid_d = 1'b1;
            locked_d      = havePrev_q && (cnt_q == period_q);
            havePrev_d    = 1'b1;
            cnt_d         = CNT_ONE;
            hcnt_d        = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            overflow_d = 1'b1;
            locked_d   = 1'b0;
            havePrev_d = 1'b0;
            cnt_d      = '0;
            hcnt_d     = '0;
            state_d    = ARM;
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
            hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, smpDly_q};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mif.period       = period_q;
  assign mif.high_time    = highTime_q;
  assign mif.period_valid = periodValid_q;
  assign mif.locked       = locked_q;
  assign mif.overflow     = overflow_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a CNT_W=16 instance for the main behaviour
// and a CNT_W=4 instance for the counter-range boundary.
module tb_clk_period_meter;

`ifdef CLK_PERIOD_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic divClk = 1'b0;
  logic measEn = 1'b0;
  int   assertCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  clk_period_meter_if #(.CNT_W(16)) bus16 ();
  clk_period_meter_if #(.CNT_W(4))  bus4 ();

  assign bus16.div_clk_in = divClk;
  assign bus16.meas_en    = measEn;
  assign bus4.div_clk_in  = divClk;
  assign bus4.meas_en     = measEn;

  clk_period_meter #(.CNT_W(16)) dut16 (.clk(clk), .reset(reset), .mif(bus16.slave));
  clk_period_meter #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .mif(bus4.slave));

  // Drive one sample of the divided clock, then settle just after the edge that takes it.
  task automatic tick(input logic v);
    @(negedge clk);
    divClk = v;
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    measEn = 1'b0;
    tick(1'b0);
    tick(1'b0);
    measEn = 1'b1;
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    measEn = 1'b0;
    divClk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    assertCount++; if (bus16.period !== 16'd0) begin failCount++; $display("[TB] FAIL reset_period got %0d exp 0", bus16.period); end
    assertCount++; if (bus16.high_time !== 16'd0) begin failCount++; $display("[TB] FAIL reset_high_time got %0d exp 0", bus16.high_time); end
    assertCount++; if (bus16.period_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid got %b exp 0", bus16.period_valid); end
    assertCount++; if (bus16.locked !== 1'b0) begin failCount++; $display("[TB] FAIL reset_locked got %b exp 0", bus16.locked); end
    assertCount++; if (bus16.overflow !== 1'b0) begin failCount++; $display("[TB] FAIL reset_overflow got %b exp 0", bus16.overflow); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_div2();
    logic expPv;
    restart();
    for (int i = 0; i <= 12; i++) begin
      tick(i % 2 == 0);
      expPv = (i >= 2 + LAT) && ((i - LAT) % 2 == 0);
      assertCount++; if (bus16.period_valid !== expPv) begin failCount++; $display("[TB] FAIL div2_valid i=%0d got %b exp %b", i, bus16.period_valid, expPv); end
      if (expPv) begin
        assertCount++; if (bus16.period !== 16'd2) begin failCount++; $display("[TB] FAIL div2_period i=%0d got %0d exp 2", i, bus16.period); end
        assertCount++; if (bus16.high_time !== 16'd1) begin failCount++; $display("[TB] FAIL div2_high i=%0d got %0d exp 1", i, bus16.high_time); end
        assertCount++; if (bus16.locked !== (i >= 4 + LAT)) begin failCount++; $display("[TB] FAIL div2_locked i=%0d got %b exp %b", i, bus16.locked, (i >= 4 + LAT)); end
      end
    end
  endtask

  task automatic test_div8();
    logic expPv;
    restart();
    assertCount++; if (bus16.period !== 16'd2) begin failCount++; $display("[TB] FAIL idle_hold_period got %0d exp 2", bus16.period); end
    assertCount++; if (bus16.locked !== 1'b0) begin failCount++; $display("[TB] FAIL idle_locked got %b exp 0", bus16.locked); end
    for (int i = 0; i <= 24 + LAT; i++) begin
      tick(i % 8 < 4);
      expPv = (i >= 8 + LAT) && ((i - LAT) % 8 == 0);
      assertCount++; if (bus16.period_valid !== expPv) begin failCount++; $display("[TB] FAIL div8_valid i=%0d got %b exp %b", i, bus16.period_valid, expPv); end
      if (expPv) begin
        assertCount++; if (bus16.period !== 16'd8) begin failCount++; $display("[TB] FAIL div8_period i=%0d got %0d exp 8", i, bus16.period); end
        assertCount++; if (bus16.high_time !== 16'd4) begin failCount++; $display("[TB] FAIL div8_high i=%0d got %0d exp 4", i, bus16.high_time); end
        assertCount++; if (bus16.locked !== (i >= 16 + LAT)) begin failCount++; $display("[TB] FAIL div8_locked i=%0d got %b exp %b", i, bus16.locked, (i >= 16 + LAT)); end
      end
    end
  endtask

  task automatic test_alternate();
    logic expPv;
    int p;
    int d;
    logic [15:0] expPer;
    logic [15:0] expHt;
    restart();
    for (int i = 0; i <= 28 + LAT; i++) begin
      p = i % 12;
      tick((p < 2) || (p >= 4 && p < 8));
      d = i - LAT;
      expPv = (d > 0) && ((d % 12 == 0) || (d % 12 == 4));
      expPer = (d % 12 == 4) ? 16'd4 : 16'd8;
      expHt = (d % 12 == 4) ? 16'd2 : 16'd4;
      assertCount++; if (bus16.period_valid !== expPv) begin failCount++; $display("[TB] FAIL alt_valid i=%0d got %b exp %b", i, bus16.period_valid, expPv); end
      if (expPv) begin
        assertCount++; if (bus16.period !== expPer) begin failCount++; $display("[TB] FAIL alt_period i=%0d got %0d exp %0d", i, bus16.period, expPer); end
        assertCount++; if (bus16.high_time !== expHt) begin failCount++; $display("[TB] FAIL alt_high i=%0d got %0d exp %0d", i, bus16.high_time, expHt); end
        assertCount++; if (bus16.locked !== 1'b0) begin failCount++; $display("[TB] FAIL alt_locked i=%0d got %b exp 0", i, bus16.locked); end
      end
    end
  endtask

  task automatic test_meas_en();
    restart();
    for (int i = 0; i <= 4 + LAT; i++) tick(i % 2 == 0);
    assertCount++; if (bus16.locked !== 1'b1) begin failCount++; $display("[TB] FAIL en_locked_before got %b exp 1", bus16.locked); end
    // Next strobe is due one edge after enable drops; it must not appear.
    measEn = 1'b0;
    tick((5 + LAT) % 2 == 0);
    assertCount++; if (bus16.locked !== 1'b0) begin failCount++; $display("[TB] FAIL en_locked_idle got %b exp 0", bus16.locked); end
    assertCount++; if (bus16.period_valid !== 1'b0) begin failCount++; $display("[TB] FAIL en_valid_k got %b exp 0", bus16.period_valid); end
    tick((6 + LAT) % 2 == 0);
    assertCount++; if (bus16.period_valid !== 1'b0) begin failCount++; $display("[TB] FAIL en_valid_k1 got %b exp 0", bus16.period_valid); end
    measEn = 1'b1;
  endtask

  task automatic test_latency();
    restart();
    for (int i = 0; i <= 5 + LAT; i++) begin
      tick(i == 0 || i == 5);
      if (i < 5 + LAT) begin
        assertCount++; if (bus16.period_valid !== 1'b0) begin failCount++; $display("[TB] FAIL lat_early i=%0d got %b exp 0", i, bus16.period_valid); end
      end
    end
    assertCount++; if (bus16.period_valid !== 1'b1) begin failCount++; $display("[TB] FAIL lat_strobe got %b exp 1", bus16.period_valid); end
    assertCount++; if (bus16.period !== 16'd5) begin failCount++; $display("[TB] FAIL lat_period got %0d exp 5", bus16.period); end
    assertCount++; if (bus16.high_time !== 16'd1) begin failCount++; $display("[TB] FAIL lat_high got %0d exp 1", bus16.high_time); end
  endtask

  task automatic test_rise_at_max();
    restart();
    for (int i = 0; i <= 15 + LAT; i++) begin
      tick(i == 0 || i == 15);
      if (i == 14 + LAT) begin
        assertCount++; if (bus4.period_valid !== 1'b0) begin failCount++; $display("[TB] FAIL max_early_valid got %b exp 0", bus4.period_valid); end
      end
    end
    assertCount++; if (bus4.period_valid !== 1'b1) begin failCount++; $display("[TB] FAIL max_valid got %b exp 1", bus4.period_valid); end
    assertCount++; if (bus4.period !== 4'd15) begin failCount++; $display("[TB] FAIL max_period got %0d exp 15", bus4.period); end
    assertCount++; if (bus4.high_time !== 4'd1) begin failCount++; $display("[TB] FAIL max_high got %0d exp 1", bus4.high_time); end
    assertCount++; if (bus4.overflow !== 1'b0) begin failCount++; $display("[TB] FAIL max_overflow got %b exp 0", bus4.overflow); end
  endtask

  task automatic test_overflow();
    logic expPv;
    restart();
    for (int i = 0; i <= 15 + LAT; i++) begin
      tick(i == 0);
      assertCount++; if (bus4.period_valid !== 1'b0) begin failCount++; $display("[TB] FAIL ovf_valid i=%0d got %b exp 0", i, bus4.period_valid); end
      assertCount++; if (bus4.overflow !== (i >= 15 + LAT)) begin failCount++; $display("[TB] FAIL ovf_flag i=%0d got %b exp %b", i, bus4.overflow, (i >= 15 + LAT)); end
    end
    for (int j = 0; j <= 4 + LAT; j++) begin
      tick(j % 2 == 0);
      expPv = (j >= 2 + LAT) && ((j - LAT) % 2 == 0);
      assertCount++; if (bus4.period_valid !== expPv) begin failCount++; $display("[TB] FAIL ovf_resume_valid j=%0d got %b exp %b", j, bus4.period_valid, expPv); end
      assertCount++; if (bus4.overflow !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_sticky j=%0d got %b exp 1", j, bus4.overflow); end
      if (expPv) begin
        assertCount++; if (bus4.period !== 4'd2) begin failCount++; $display("[TB] FAIL ovf_resume_period j=%0d got %0d exp 2", j, bus4.period); end
      end
    end
    measEn = 1'b0;
    tick(1'b0);
    assertCount++; if (bus4.overflow !== 1'b0) begin failCount++; $display("[TB] FAIL ovf_clear got %b exp 0", bus4.overflow); end
    measEn = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic expPv;
    restart();
    for (int i = 0; i <= 4 + LAT; i++) tick(i % 2 == 0);
    assertCount++; if (bus16.locked !== 1'b1) begin failCount++; $display("[TB] FAIL mid_locked_before got %b exp 1", bus16.locked); end
    reset = 1'b1;
    #2;
    assertCount++; if (bus16.period !== 16'd0) begin failCount++; $display("[TB] FAIL mid_period got %0d exp 0", bus16.period); end
    assertCount++; if (bus16.high_time !== 16'd0) begin failCount++; $display("[TB] FAIL mid_high got %0d exp 0", bus16.high_time); end
    assertCount++; if (bus16.locked !== 1'b0) begin failCount++; $display("[TB] FAIL mid_locked got %b exp 0", bus16.locked); end
    assertCount++; if (bus16.period_valid !== 1'b0) begin failCount++; $display("[TB] FAIL mid_valid got %b exp 0", bus16.period_valid); end
    @(negedge clk);
    divClk = 1'b0;
    reset = 1'b0;
    for (int i = 0; i <= 4 + LAT; i++) begin
      tick(i % 2 == 0);
      expPv = (i >= 2 + LAT) && ((i - LAT) % 2 == 0);
      assertCount++; if (bus16.period_valid !== expPv) begin failCount++; $display("[TB] FAIL mid_after_valid i=%0d got %b exp %b", i, bus16.period_valid, expPv); end
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_div8();
    test_alternate();
    test_meas_en();
    test_latency();
    test_rise_at_max();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
